game_phase_ctrl: RTL and testbench
==================================

Name: game_phase_ctrl

Overview:
- Game-level sequencer that owns the boss HP counter, the boss attack-phase selects (enma1..enma4), the player life count and the gameover/win flags.
- Consumes hit pulses from the collision logic and the start key from the keyboard decoder.
- Drives the boss, reimu and vga_RGB blocks, replacing their tied-off configuration inputs.
- Runs on the system clock; frame-rate behaviour uses a one-cycle tick enable.

Parameters:
- BOSS_HP_MAX, 450, boss HP loaded at game start; must fit in 10 bits.
- BOSS_DMG, 1, HP removed per accepted boss_hit.
- LIVES_INIT, 3, player lives at game start (1..3).
- CLEAR_TICKS, 32, ticks spent in PHASE_CLEAR between attack phases.
- INVULN_TICKS, 64, ticks of player invulnerability after a hit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tick  in  1  one-clk pulse per game frame (synchronised clk22 edge)
- start  in  1  one-clk pulse, start/confirm key
- boss_hit  in  1  one-clk pulse, player bullet hit boss
- reimu_hit  in  1  one-clk pulse, enemy bullet hit player
- bosshp  out  10  current boss HP
- enma1, enma2, enma3, enma4  out  1 each  attack-phase selects, at most one high
- lives  out  2  remaining lives
- invuln  out  1  player invulnerable (vga blinks the sprite)
- freeze  out  1  high in PHASE_CLEAR; bullets and boss movement halt
- gameover  out  1  high in LOSE
- win  out  1  high in WIN
- state  out  3  IDLE=0, PLAY=1, PHASE_CLEAR=2, WIN=3, LOSE=4

Behaviour:
- Reset (async, immediate): state=IDLE; bosshp=BOSS_HP_MAX; lives=LIVES_INIT; enma*=0; invuln=0; freeze=0; gameover=0; win=0; all counters 0. Reset asserted mid-game aborts immediately.
- Thresholds: TH1=BOSS_HP_MAX*3/4, TH2=BOSS_HP_MAX/2, TH3=BOSS_HP_MAX/4, integer division (450 -> 337, 225, 112).
- Phase index p derived from HP: hp>TH1 -> 1; hp>TH2 -> 2; hp>TH3 -> 3; otherwise 4.
- In PLAY, enma_p=1 and the others are 0. In every other state all enma are 0.
- IDLE:
  - start -> PLAY on the next clk.
  - Entering PLAY loads bosshp=BOSS_HP_MAX, lives=LIVES_INIT, invuln=0.
  - All hits ignored.
- PLAY, boss_hit:
  - Accepted only in this state.
  - bosshp <= sat0(bosshp-BOSS_DMG); registered, visible 1 clk after the pulse.
  - New HP == 0 -> WIN.
  - New HP moves to a higher phase index -> PHASE_CLEAR, clear counter=0.
- PLAY, reimu_hit:
  - Ignored while invuln=1.
  - Otherwise lives <= lives-1, invuln <= 1, invuln counter=0.
  - lives reaching 0 -> LOSE.
- Simultaneous boss_hit and reimu_hit in PLAY: both are applied in the same clk.
- Next-state priority: LOSE > WIN > PHASE_CLEAR > PLAY.
- PHASE_CLEAR:
  - freeze=1; boss_hit and reimu_hit ignored.
  - The clear counter increments on tick.
  - At count CLEAR_TICKS-1 with tick -> PLAY; the new enma goes high in the same transition.
  - The invuln counter keeps running in PLAY and PHASE_CLEAR.
- Invuln: the counter increments on tick while invuln=1. At INVULN_TICKS-1 with tick, invuln <= 0.
- WIN: win=1; bosshp holds 0. start -> IDLE.
- LOSE: gameover=1; bosshp holds its value. start -> IDLE.
- Leaving to IDLE reloads bosshp and lives and clears win/gameover.
- start is ignored in PLAY and PHASE_CLEAR.
- A tick coincident with any event is processed normally in the same clk.
- All outputs are registered.

Decomposition:
- Shared package game_pkg:
  - state encodings GS_IDLE..GS_LOSE
  - HP width (10)
  - default BOSS_HP_MAX
- One natural sub-module: tick_counter (tick-enabled counter with clear and terminal-count flag).
  - Instantiated twice, for the phase-clear and invulnerability timers.

Test Plan:
1. Reset, then start pulse, then 113 boss_hit pulses spaced 2 clk -> state PLAY; bosshp 450->337; enma1 high until hp=337. Hp 337 enters PHASE_CLEAR with freeze=1 and all enma 0. After 32 ticks -> PLAY with enma2=1.
2. In PLAY, three reimu_hit pulses, each 70 ticks apart -> lives 3->2->1->0. invuln high for exactly 64 ticks after each hit. The third hit gives state=LOSE, gameover=1.
3. reimu_hit twice within 10 ticks -> lives decrement once; the second hit is ignored while invuln=1.
4. Drive bosshp to 1 in phase 4, with lives=1 and invuln=0, then boss_hit and reimu_hit in the same clk -> state=LOSE, gameover=1, win=0, bosshp=0.
5. Boss_hit pulses during PHASE_CLEAR and IDLE -> bosshp unchanged. Then drive to hp=0 -> WIN, win=1. Start -> IDLE with bosshp=450, lives=3, win=0.
6. Assert rst mid-PHASE_CLEAR with clk stopped -> all outputs reach reset values without a clock edge. Release, then start -> PLAY, enma1=1.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-level sequencer: state encodings, boss HP
// width, default boss HP, and small helpers for HP arithmetic and phase
// selection.
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int HP_W            = 10;
    localparam int BOSS_HP_MAX_DEF = 450;

    typedef enum logic [2:0] {
        GS_IDLE        = 3'd0,
        GS_PLAY        = 3'd1,
        GS_PHASE_CLEAR = 3'd2,
        GS_WIN         = 3'd3,
        GS_LOSE        = 3'd4
    } game_state_e;

    // HP subtraction that floors at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                 input logic [HP_W-1:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return {HP_W{1'b0}};
        end
    endfunction

    // Zero-based attack phase (0 -> enma1 ... 3 -> enma4) for a given HP.
    function automatic logic [1:0] phase_idx(input logic [HP_W-1:0] hp,
                                             input logic [HP_W-1:0] th1,
                                             input logic [HP_W-1:0] th2,
                                             input logic [HP_W-1:0] th3);
        if (hp > th1) begin
            return 2'd0;
        end else if (hp > th2) begin
            return 2'd1;
        end else if (hp > th3) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/game_phase_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_phase_ctrl_if
// Bundles the event inputs (tick, start, hit pulses) and the game status
// outputs of game_phase_ctrl.
//   master : drives tick/start/boss_hit/reimu_hit, observes status
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface game_phase_ctrl_if;
    import game_pkg::*;

    logic            tick;
    logic            start;
    logic            boss_hit;
    logic            reimu_hit;
    logic [HP_W-1:0] bosshp;
    logic            enma1;
    logic            enma2;
    logic            enma3;
    logic            enma4;
    logic [1:0]      lives;
    logic            invuln;
    logic            freeze;
    logic            gameover;
    logic            win;
    logic [2:0]      state;

    modport master (
        output tick, start, boss_hit, reimu_hit,
        input  bosshp, enma1, enma2, enma3, enma4, lives, invuln, freeze,
               gameover, win, state
    );

    modport slave (
        input  tick, start, boss_hit, reimu_hit,
        output bosshp, enma1, enma2, enma3, enma4, lives, invuln, freeze,
               gameover, win, state
    );

endinterface

// File: rtl/tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// Tick-enabled counter used for frame-based timers.
//   clk, rst : system clock, async active-high reset
//   clr      : synchronous clear to zero (wins over counting)
//   en       : timer running
//   tick     : one-cycle frame pulse
//   done     : this tick is the TERMINAL-th counted tick (count==TERMINAL-1)
// The count wraps to zero when done fires, so the timer is ready for reuse.
// -----------------------------------------------------------------------------
module tick_counter #(
    parameter int TERMINAL = 32,
    parameter int WIDTH    = $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);

    // Next-count selection: clear, count on tick, wrap at terminal.
    always_comb begin
        count_d = count_q;
        done    = 1'b0;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (en && tick) begin
            if (at_last) begin
                count_d = {WIDTH{1'b0}};
                done    = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// -----------------------------------------------------------------------------
// game_phase_ctrl
// Game-level sequencer: owns boss HP, attack-phase selects, player lives,
// invulnerability window and win/gameover flags.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of game_phase_ctrl_if
//              in : tick, start, boss_hit, reimu_hit (one-cycle pulses)
//              out: bosshp, enma1..4, lives, invuln, freeze, gameover, win,
//                   state
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int BOSS_HP_MAX  = BOSS_HP_MAX_DEF,
    parameter int BOSS_DMG     = 1,
    parameter int LIVES_INIT   = 3,
    parameter int CLEAR_TICKS  = 32,
    parameter int INVULN_TICKS = 64
) (
    input logic               clk,
    input logic               rst,
    game_phase_ctrl_if.slave  bus
);

    localparam logic [HP_W-1:0] HP_MAX = HP_W'(BOSS_HP_MAX);
    localparam logic [HP_W-1:0] DMG    = HP_W'(BOSS_DMG);
    localparam logic [HP_W-1:0] TH1    = HP_W'(BOSS_HP_MAX * 3 / 4);
    localparam logic [HP_W-1:0] TH2    = HP_W'(BOSS_HP_MAX / 2);
    localparam logic [HP_W-1:0] TH3    = HP_W'(BOSS_HP_MAX / 4);
    localparam logic [1:0]      LIVES0 = 2'(LIVES_INIT);

    game_state_e     state_q, state_d;
    logic [HP_W-1:0] bosshp_q, bosshp_d;
    logic [1:0]      lives_q, lives_d;
    logic            invuln_q, invuln_d;
    logic [3:0]      enma_q, enma_d;
    logic            freeze_q, freeze_d;
    logic            gameover_q, gameover_d;
    logic            win_q, win_d;

    logic            clear_start_s;
    logic            clear_done_s;
    logic            inv_clr_s;
    logic            inv_done_s;
    logic            reimu_acc_s;
    logic [1:0]      lives_dec_s;

    tick_counter #(.TERMINAL(CLEAR_TICKS)) u_clear_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_start_s),
        .en   (state_q == GS_PHASE_CLEAR),
        .tick (bus.tick),
        .done (clear_done_s)
    );

    tick_counter #(.TERMINAL(INVULN_TICKS)) u_invuln_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (inv_clr_s),
        .en   (invuln_q),
        .tick (bus.tick),
        .done (inv_done_s)
    );

    assign lives_dec_s = lives_q - 2'd1;

    // Next-state, HP/lives/invuln update and registered-output precompute.
    always_comb begin
        state_d       = state_q;
        bosshp_d      = bosshp_q;
        lives_d       = lives_q;
        invuln_d      = invuln_q;
        clear_start_s = 1'b0;
        inv_clr_s     = 1'b0;
        reimu_acc_s   = 1'b0;

        // The invulnerability window expires independently of game state.
        if (invuln_q && inv_done_s) begin
            invuln_d = 1'b0;
        end else begin
            invuln_d = invuln_q;
        end

        case (state_q)
            GS_IDLE: begin
                invuln_d  = 1'b0;
                inv_clr_s = 1'b1;
                if (bus.start) begin
                    state_d  = GS_PLAY;
                    bosshp_d = HP_MAX;
                    lives_d  = LIVES0;
                end else begin
                    state_d = GS_IDLE;
                end
            end
            GS_PLAY: begin
                if (bus.boss_hit) begin
                    bosshp_d = sat_sub(bosshp_q, DMG);
                end else begin
                    bosshp_d = bosshp_q;
                end
                if (bus.reimu_hit && !invuln_q) begin
                    reimu_acc_s = 1'b1;
                    lives_d     = lives_dec_s;
                    invuln_d    = 1'b1;
                    inv_clr_s   = 1'b1;
                end else begin
                    reimu_acc_s = 1'b0;
                end
                // Priority LOSE > WIN > PHASE_CLEAR > PLAY.
                if (reimu_acc_s && (lives_dec_s == 2'd0)) begin
                    state_d = GS_LOSE;
                end else if (bosshp_d == {HP_W{1'b0}}) begin
                    state_d = GS_WIN;
                end else if (phase_idx(bosshp_d, TH1, TH2, TH3) >
                             phase_idx(bosshp_q, TH1, TH2, TH3)) begin
                    state_d       = GS_PHASE_CLEAR;
                    clear_start_s = 1'b1;
                end else begin
                    state_d = GS_PLAY;
                end
            end
            GS_PHASE_CLEAR: begin
                if (clear_done_s) begin
                    state_d = GS_PLAY;
                end else begin
                    state_d = GS_PHASE_CLEAR;
                end
            end
            GS_WIN, GS_LOSE: begin
                if (bus.start) begin
                    state_d  = GS_IDLE;
                    bosshp_d = HP_MAX;
                    lives_d  = LIVES0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = GS_IDLE;
                bosshp_d = HP_MAX;
                lives_d  = LIVES0;
                invuln_d = 1'b0;
            end
        endcase

        // Phase select follows the HP that will be visible next cycle.
        if (state_d == GS_PLAY) begin
            enma_d = 4'b0001 << phase_idx(bosshp_d, TH1, TH2, TH3);
        end else begin
            enma_d = 4'b0000;
        end
        freeze_d   = (state_d == GS_PHASE_CLEAR);
        gameover_d = (state_d == GS_LOSE);
        win_d      = (state_d == GS_WIN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GS_IDLE;
            bosshp_q   <= HP_MAX;
            lives_q    <= LIVES0;
            invuln_q   <= 1'b0;
            enma_q     <= 4'b0000;
            freeze_q   <= 1'b0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bosshp_q   <= bosshp_d;
            lives_q    <= lives_d;
            invuln_q   <= invuln_d;
            enma_q     <= enma_d;
            freeze_q   <= freeze_d;
            gameover_q <= gameover_d;
            win_q      <= win_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.bosshp   = bosshp_q;
    assign bus.lives    = lives_q;
    assign bus.invuln   = invuln_q;
    assign bus.enma1    = enma_q[0];
    assign bus.enma2    = enma_q[1];
    assign bus.enma3    = enma_q[2];
    assign bus.enma4    = enma_q[3];
    assign bus.freeze   = freeze_q;
    assign bus.gameover = gameover_q;
    assign bus.win      = win_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_phase_ctrl
// Directed self-checking bench for game_phase_ctrl: a per-cycle vector table
// for basic behaviour plus hand-written sequences for phase clears, the
// invulnerability window, end-of-game cases and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_game_phase_ctrl;

    logic clk;
    logic clk_en;
    logic rst;
    int   checks;
    int   errors;
    int   m_hp;

    game_phase_ctrl_if bus_if ();

    game_phase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Gateable clock so reset can be exercised with no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic       tick;
        logic       start;
        logic       bhit;
        logic       rhit;
        logic [2:0] st;
        logic [9:0] hp;
        logic [1:0] lv;
        logic [3:0] enma;
        logic       inv;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [3:0] get_enma();
        return {bus_if.enma4, bus_if.enma3, bus_if.enma2, bus_if.enma1};
    endfunction

    // Expected phase select for a given HP, thresholds 337/225/112.
    function automatic logic [3:0] exp_enma(input int hp);
        if (hp > 337) return 4'b0001;
        else if (hp > 225) return 4'b0010;
        else if (hp > 112) return 4'b0100;
        else return 4'b1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic b, input logic r);
        bus_if.tick      = t;
        bus_if.start     = s;
        bus_if.boss_hit  = b;
        bus_if.reimu_hit = r;
        @(posedge clk);
        #1;
        bus_if.tick      = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.boss_hit  = 1'b0;
        bus_if.reimu_hit = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Boss hits spaced 2 clk; walks each phase clear when run_clear is set.
    task automatic drive_boss(input int n, input bit run_clear);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            m_hp--;
            check("hit_hp", bus_if.bosshp, m_hp);
            if (m_hp == 0) begin
                check("win_state", bus_if.state, 3);
                check("win_flag", bus_if.win, 1);
                check("win_enma", get_enma(), 0);
            end else if (m_hp == 337 || m_hp == 225 || m_hp == 112) begin
                check("clr_state", bus_if.state, 2);
                check("clr_freeze", bus_if.freeze, 1);
                check("clr_enma", get_enma(), 0);
                if (run_clear) begin
                    run_ticks(31);
                    check("clr_hold", bus_if.state, 2);
                    run_ticks(1);
                    check("clr_exit", bus_if.state, 1);
                    check("clr_new_enma", get_enma(), exp_enma(m_hp));
                end
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        clk_en = 1'b1;
        rst    = 1'b1;
        bus_if.tick      = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.boss_hit  = 1'b0;
        bus_if.reimu_hit = 1'b0;

        //            tick  start bhit  rhit   st    hp      lv    enma     inv
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 10'd450, 2'd3, 4'b0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 10'd450, 2'd3, 4'b0000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 10'd450, 2'd3, 4'b0001, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 10'd450, 2'd3, 4'b0001, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 10'd449, 2'd3, 4'b0001, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 10'd448, 2'd3, 4'b0001, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 10'd448, 2'd2, 4'b0001, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 10'd448, 2'd2, 4'b0001, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 10'd447, 2'd2, 4'b0001, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 10'd447, 2'd2, 4'b0001, 1'b1};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", bus_if.state, 0);
        check("rst_hp", bus_if.bosshp, 450);
        check("rst_lives", bus_if.lives, 3);
        check("rst_enma", get_enma(), 0);
        check("rst_invuln", bus_if.invuln, 0);
        check("rst_freeze", bus_if.freeze, 0);
        check("rst_gameover", bus_if.gameover, 0);
        check("rst_win", bus_if.win, 0);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].tick, vecs[i].start, vecs[i].bhit, vecs[i].rhit);
            check("vec_state", bus_if.state, vecs[i].st);
            check("vec_hp", bus_if.bosshp, vecs[i].hp);
            check("vec_lives", bus_if.lives, vecs[i].lv);
            check("vec_enma", get_enma(), vecs[i].enma);
            check("vec_invuln", bus_if.invuln, vecs[i].inv);
        end

        // Phase 1 -> clear -> phase 2; hits ignored during clear.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        m_hp = 450;
        drive_boss(112, 1'b1);
        check("p1_hp338_enma", get_enma(), 4'b0001);
        check("p1_hp338_state", bus_if.state, 1);
        drive_boss(1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_bhit_ign", bus_if.bosshp, 337);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_rhit_ign", bus_if.lives, 3);
        run_ticks(31);
        check("clear_31", bus_if.state, 2);
        run_ticks(1);
        check("clear_done_state", bus_if.state, 1);
        check("clear_done_enma", get_enma(), 4'b0010);
        check("clear_done_freeze", bus_if.freeze, 0);

        // Three spaced player hits -> LOSE; early second hit ignored.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check("rh_lives", bus_if.lives, 2 - k);
            if (k == 2) begin
                check("rh_lose", bus_if.state, 4);
                check("rh_gameover", bus_if.gameover, 1);
                check("rh_lose_enma", get_enma(), 0);
            end else begin
                check("rh_invuln_set", bus_if.invuln, 1);
                for (int j = 1; j <= 70; j++) begin
                    run_ticks(1);
                    if (j == 5 && k == 0) begin
                        step(1'b0, 1'b0, 1'b0, 1'b1);
                        check("rh_ignored", bus_if.lives, 2);
                    end
                    if (j == 63) check("rh_inv_63", bus_if.invuln, 1);
                    if (j == 64) check("rh_inv_64", bus_if.invuln, 0);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lose_idle_state", bus_if.state, 0);
        check("lose_idle_lives", bus_if.lives, 3);
        check("lose_idle_go", bus_if.gameover, 0);

        // Last HP and last life in the same clk -> LOSE with HP 0.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_ticks(64);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_ticks(64);
        check("sim_lives1", bus_if.lives, 1);
        check("sim_inv0", bus_if.invuln, 0);
        m_hp = 450;
        drive_boss(449, 1'b1);
        check("sim_enma4", get_enma(), 4'b1000);
        check("sim_play", bus_if.state, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("sim_state", bus_if.state, 4);
        check("sim_gameover", bus_if.gameover, 1);
        check("sim_win", bus_if.win, 0);
        check("sim_hp", bus_if.bosshp, 0);

        // WIN and return to IDLE.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_bhit_ign", bus_if.bosshp, 450);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        m_hp = 450;
        drive_boss(450, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("win_hold_hp", bus_if.bosshp, 0);
        check("win_hold_state", bus_if.state, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("win_idle_state", bus_if.state, 0);
        check("win_idle_hp", bus_if.bosshp, 450);
        check("win_idle_lives", bus_if.lives, 3);
        check("win_idle_win", bus_if.win, 0);

        // Async reset mid-clear with the clock stopped.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        m_hp = 450;
        drive_boss(113, 1'b0);
        run_ticks(5);
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", bus_if.state, 0);
        check("arst_hp", bus_if.bosshp, 450);
        check("arst_lives", bus_if.lives, 3);
        check("arst_freeze", bus_if.freeze, 0);
        check("arst_enma", get_enma(), 0);
        #2;
        rst = 1'b0;
        clk_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("arst_play", bus_if.state, 1);
        check("arst_enma1", get_enma(), 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
